// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the vga_adapter plot port among four rectangle
// requesters. Round-robin grant in IDLE, one pixel per cycle in DRAW with
// screen clipping, then a done pulse back to the granted requester.
module vga_plot_arbiter #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [31:0] rect_x,
   input  logic [27:0] rect_y,
   input  logic [31:0] rect_w,
   input  logic [27:0] rect_h,
   input  logic [11:0] rect_colour,
   output logic [3:0]  ack,
   output logic [3:0]  done,
   output logic        busy,
   output logic [7:0]  x,
   output logic [6:0]  y,
   output logic [2:0]  colour,
   output logic        plot
);

   localparam int NUM_REQ = 4;
   // limits sized to the unwrapped coordinate sums so wrapped pixels clip
   localparam logic [8:0] LIM_X = 9'(SCREEN_W);
   localparam logic [7:0] LIM_Y = 8'(SCREEN_H);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   typedef struct packed {
      logic [7:0] x0;
      logic [6:0] y0;
      logic [7:0] w;
      logic [6:0] h;
      logic [2:0] colour;
   } job_t;

   // per-requester views of the packed rectangle buses
   logic [NUM_REQ-1:0][7:0] rx_a;
   logic [NUM_REQ-1:0][6:0] ry_a;
   logic [NUM_REQ-1:0][7:0] rw_a;
   logic [NUM_REQ-1:0][6:0] rh_a;
   logic [NUM_REQ-1:0][2:0] rc_a;

   assign rx_a = rect_x;
   assign ry_a = rect_y;
   assign rw_a = rect_w;
   assign rh_a = rect_h;
   assign rc_a = rect_colour;

   state_t     state, state_d;
   job_t       job;
   logic [1:0] g;
   logic [1:0] rr_ptr;
   logic [1:0] win;
   logic [1:0] idx;
   logic       win_vld;
   logic       win_empty;
   logic [7:0] cx;
   logic [6:0] cy;
   logic [8:0] sum_x;
   logic [7:0] sum_y;
   logic       last_col;
   logic       last_px;

   // raster position; sums are one bit wider so off-screen pixels never alias
   assign sum_x    = {1'b0, job.x0} + {1'b0, cx};
   assign sum_y    = {1'b0, job.y0} + {1'b0, cy};
   assign last_col = (cx == job.w - 8'd1);
   assign last_px  = last_col && (cy == job.h - 7'd1);

   // round-robin search starting at rr_ptr; first requester found wins
   always_comb begin
      win     = rr_ptr;
      win_vld = 1'b0;
      idx     = rr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = rr_ptr + i[1:0];
         if (!win_vld && req[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   assign win_empty = (rw_a[win] == 8'd0) || (rh_a[win] == 7'd0);

   // next-state logic
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (win_vld) state_d = win_empty ? S_DONE : S_DRAW;
         S_DRAW:  if (last_px) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state register; reset abandons any job in flight
   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_d;
   end

   // datapath: job latch, raster counters, registered pixel and handshake outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         ack    <= '0;
         done   <= '0;
         busy   <= 1'b0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         rr_ptr <= '0;
         g      <= '0;
         job    <= '0;
         cx     <= '0;
         cy     <= '0;
      end else begin
         ack  <= '0;
         done <= '0;
         plot <= 1'b0;
         busy <= (state_d != S_IDLE);
         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  job.x0     <= rx_a[win];
                  job.y0     <= ry_a[win];
                  job.w      <= rw_a[win];
                  job.h      <= rh_a[win];
                  job.colour <= rc_a[win];
                  g          <= win;
                  rr_ptr     <= win + 2'd1;
                  cx         <= '0;
                  cy         <= '0;
                  ack[win]   <= 1'b1;
               end
            end
            S_DRAW: begin
               // clipped pixels still consume their cycle, just without plot
               x      <= sum_x[7:0];
               y      <= sum_y[6:0];
               colour <= job.colour;
               plot   <= (sum_x < LIM_X) && (sum_y < LIM_Y);
               if (last_col) begin
                  cx <= '0;
                  cy <= cy + 7'd1;
               end else begin
                  cx <= cx + 8'd1;
               end
            end
            S_DONE: done[g] <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: table of single-requester jobs plus hand-written
// round-robin and reset-mid-draw sequences. Expected pixels are pushed to a
// queue when a job is issued and popped whenever the DUT raises plot.
module tb_vga_plot_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] rect_x;
   logic [27:0] rect_y;
   logic [31:0] rect_w;
   logic [27:0] rect_h;
   logic [11:0] rect_colour;
   logic [3:0]  ack;
   logic [3:0]  done;
   logic        busy;
   logic [7:0]  x;
   logic [6:0]  y;
   logic [2:0]  colour;
   logic        plot;

   always #5 clock = ~clock;

   vga_plot_arbiter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
      .clock(clock), .reset(reset), .req(req),
      .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
      .rect_colour(rect_colour),
      .ack(ack), .done(done), .busy(busy),
      .x(x), .y(y), .colour(colour), .plot(plot)
   );

   typedef struct packed {
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc;
   } pix_t;

   typedef struct {
      int         g;
      int         rx, ry, rw, rh, rc;
      logic [3:0] exp_ack;
      int         exp_lat;
      int         exp_plots;
   } vec_t;

   pix_t       exp_q[$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         plot_cnt = 0;
   logic [7:0] last_x = '0;
   logic [6:0] last_y = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // advance one cycle and sample outputs on the falling edge
   task automatic tick();
      pix_t p;
      @(posedge clock);
      @(negedge clock);
      cyc++;
      if (ack != 4'd0 || done != 4'd0)
         check("ack_done_onehot", 32'($onehot({ack, done})), 32'd1);
      if (plot) begin
         plot_cnt++;
         last_x = x;
         last_y = y;
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pix_extra: got (%0d,%0d,c%0d), required no plot", x, y, colour);
         end else begin
            p = exp_q.pop_front();
            check("pix", {x, y, colour}, p);
         end
      end
   endtask

   // row-major visible pixels of a rectangle, clipped to 160x120
   task automatic push_rect(input int rx, input int ry, input int rw, input int rh, input int rc);
      for (int r = 0; r < rh; r++)
         for (int c = 0; c < rw; c++)
            if (rx + c < 160 && ry + r < 120)
               exp_q.push_back({8'(rx + c), 7'(ry + r), 3'(rc)});
   endtask

   task automatic set_lane(input int g, input int rx, input int ry, input int rw, input int rh, input int rc);
      rect_x[8*g +: 8]      = rx[7:0];
      rect_y[7*g +: 7]      = ry[6:0];
      rect_w[8*g +: 8]      = rw[7:0];
      rect_h[7*g +: 7]      = rh[6:0];
      rect_colour[3*g +: 3] = rc[2:0];
   endtask

   task automatic wait_ack(output int gi);
      gi = -1;
      for (int i = 0; i < 25000; i++) begin
         tick();
         if (ack != 4'd0) begin
            for (int b = 0; b < 4; b++) if (ack[b]) gi = b;
            return;
         end
      end
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack in 25000 cycles, required an ack");
   endtask

   task automatic wait_done(input bit scramble);
      for (int i = 0; i < 25000; i++) begin
         tick();
         if (scramble) begin
            rect_x      = $urandom;
            rect_y      = 28'($urandom);
            rect_w      = $urandom;
            rect_h      = 28'($urandom);
            rect_colour = 12'($urandom);
         end
         if (done != 4'd0) return;
      end
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no done in 25000 cycles, required a done");
   endtask

   task automatic run_vec(input vec_t v, input bit scramble);
      int gi;
      int a_at;
      set_lane(v.g, v.rx, v.ry, v.rw, v.rh, v.rc);
      push_rect(v.rx, v.ry, v.rw, v.rh, v.rc);
      plot_cnt = 0;
      req[v.g] = 1'b1;
      wait_ack(gi);
      a_at = cyc;
      check("ack", ack, v.exp_ack);
      check("busy_on_ack", busy, 1);
      req[v.g] = 1'b0;
      wait_done(scramble);
      check("done", done, v.exp_ack);
      check("latency", cyc - a_at, v.exp_lat);
      check("plot_count", plot_cnt, v.exp_plots);
      check("busy_at_done", busy, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   vec_t vecs[7];
   vec_t full;
   int   gi;
   int   ord[2];

   initial begin
      // single-lane jobs: lane, x, y, w, h, colour, ack/done bit, ack->done cycles, plots
      vecs[0] = '{1,  10, 110,  4, 4, 1, 4'b0010, 17, 16}; // basic 4x4
      vecs[1] = '{3, 158, 118,  4, 4, 5, 4'b1000, 17,  4}; // bottom-right corner clip
      vecs[2] = '{2,  20,  30,  0, 5, 7, 4'b0100,  1,  0}; // zero width
      vecs[3] = '{0,   5,   7,  3, 0, 2, 4'b0001,  1,  0}; // zero height
      vecs[4] = '{2, 150, 100, 12, 3, 6, 4'b0100, 37, 30}; // right-edge clip
      vecs[5] = '{0, 255,   0,  2, 2, 3, 4'b0001,  5,  0}; // x sum passes 255, all clipped
      vecs[6] = '{1, 159, 119,  1, 1, 4, 4'b0010,  2,  1}; // last visible pixel only

      reset       = 1'b1;
      req         = '0;
      rect_x      = '0;
      rect_y      = '0;
      rect_w      = '0;
      rect_h      = '0;
      rect_colour = '0;
      tick();
      tick();
      check("rst_ack", ack, 0);
      check("rst_done", done, 0);
      check("rst_busy", busy, 0);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      check("rst_colour", colour, 0);
      check("rst_plot", plot, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

      // y sum passes 127: every pixel clipped
      vecs[0] = '{1, 0, 127, 2, 3, 4, 4'b0010, 7, 0};
      run_vec(vecs[0], 1'b0);

      // full-screen erase with rect inputs scrambled while drawing
      full = '{0, 0, 0, 160, 120, 0, 4'b0001, 19201, 19200};
      run_vec(full, 1'b1);
      check("erase_last_x", last_x, 159);
      check("erase_last_y", last_y, 119);

      // round-robin: all four held from reset, each dropped on its ack
      reset = 1'b1;
      for (int i = 0; i < 4; i++) set_lane(i, i * 10, 5, 1, 1, i + 1);
      req = 4'b1111;
      tick();
      tick();
      exp_q.delete();
      for (int i = 0; i < 4; i++) push_rect(i * 10, 5, 1, 1, i + 1);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(gi);
         check("rr_order", gi, k);
         if (gi >= 0) req[gi] = 1'b0;
         wait_done(1'b0);
         check("rr_done", done, 32'(1) << k);
      end
      // pointer is back at 0: lanes 0 and 2 raised together
      set_lane(0, 30, 40, 2, 1, 6);
      set_lane(2, 60, 40, 1, 2, 3);
      push_rect(30, 40, 2, 1, 6);
      push_rect(60, 40, 1, 2, 3);
      ord[0] = 0;
      ord[1] = 2;
      req = 4'b0101;
      for (int k = 0; k < 2; k++) begin
         wait_ack(gi);
         check("rr2_order", gi, ord[k]);
         if (gi >= 0) req[gi] = 1'b0;
         wait_done(1'b0);
      end
      check("rr_queue_drained", exp_q.size(), 0);

      // reset mid-draw on lane 1 (pointer moves to 2), then lanes 0 and 3 compete
      set_lane(1, 0, 0, 10, 2, 5);
      set_lane(0, 50, 50, 1, 1, 2);
      set_lane(3, 70, 60, 1, 1, 7);
      push_rect(0, 0, 7, 1, 5);
      req = 4'b0010;
      wait_ack(gi);
      check("mid_grant", gi, 1);
      req = 4'b0000;
      plot_cnt = 0;
      for (int i = 0; i < 100 && plot_cnt < 7; i++) tick();
      reset = 1'b1;
      tick();
      check("mid_rst_plot", plot, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_queue", exp_q.size(), 0);
      reset = 1'b0;
      req   = 4'b1001;
      push_rect(50, 50, 1, 1, 2);
      push_rect(70, 60, 1, 1, 7);
      wait_ack(gi);
      check("post_rst_grant", gi, 0);
      req[0] = 1'b0;
      wait_done(1'b0);
      check("post_rst_done", done, 32'b0001);
      wait_ack(gi);
      check("post_rst_grant2", gi, 3);
      req[3] = 1'b0;
      wait_done(1'b0);
      check("post_rst_done2", done, 32'b1000);
      check("post_rst_queue", exp_q.size(), 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
